regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter that shares the register file's single write port between two producers: the ALU result path (source A, from EX) and the load-data path (source B, from MEM). Each source has a one-entry holding slot with a valid/ready handshake. The arbiter grants the oldest occupied slot and drives a registered one-cycle write strobe into the register file. It also exports a pending-destination bitmask for the hazard/stall logic in ID.

## Interface
Parameters:
- `ADDR_W`, default 5: register address width.
- `DATA_W`, default 32: register data width.
- `NREG`, default 32: number of architectural registers; width of `pending`.

Ports:
- `clk`  in  1  — the single clock.
- `rst`  in  1  — reset; synchronous, active-high.
- `rdy`  in  1  — global ready; 0 freezes the block.
- `a_valid`  in  1  — ALU write-back request.
- `a_ready`  out  1  — slot A can accept this cycle.
- `a_addr`  in  ADDR_W  — ALU destination register.
- `a_data`  in  DATA_W  — ALU result.
- `b_valid`  in  1  — load write-back request.
- `b_ready`  out  1  — slot B can accept this cycle.
- `b_addr`  in  ADDR_W  — load destination register.
- `b_data`  in  DATA_W  — load data.
- `we`  out  1  — register-file write enable (registered).
- `waddr`  out  ADDR_W  — register-file write address (registered).
- `wdata`  out  DATA_W  — register-file write data (registered).
- `pending`  out  NREG  — bit r=1 while any held slot targets register r; bit 0 always 0.
- `busy`  out  1  — at least one slot is occupied.

## Operation
- State:
  - per-slot `valid`, `addr` and `data`;
  - `b_older` flag, meaning slot B holds the older entry;
  - output registers `we`, `waddr`, `wdata`.
- Acceptance:
  - `x_ready = !rst && rdy && (!slot_x.valid || grant_x)`.
  - A transfer occurs on a rising edge where `x_valid && x_ready`.
  - `x_ready` depends only on slot state and `rdy`, never on `x_valid`, so there is no combinational loop.
- Grant is decided combinationally from slot state only:
  - If exactly one slot is valid, grant it.
  - If both are valid, grant B when `b_older` is set, otherwise grant A.
  - If neither is valid, there is no grant.
- Age rules (`b_older` updates on the accepting edge):
  - A slot loaded while the other slot stays valid and is not granted is younger than the other.
  - Both slots loading on the same edge: B is older, because the MEM-stage instruction precedes the EX-stage one in program order.
  - Any other single load: B is older when it is the only valid slot, or when A is the freshly loaded slot.
- On each edge with `rdy=1`:
  - The granted slot's contents move into the output registers.
  - `we` is set to `(granted && addr != 0)`, so writes to x0 are consumed and dropped.
  - The granted slot clears unless it is reloaded on the same edge.
  - With no grant, `we` goes to 0 and `waddr`/`wdata` hold their values.
- With `rdy=0`: no accepts, no grants, all state holds, and `we` is forced to 0 on that edge.
- `pending` is the OR of the one-hot decodes of all valid slot addresses, with bit 0 masked.
  - The entry in the output-register stage is not reported; the register file forwards `wdata` on address match while `we=1`.
- Reset values: all slots invalid, `b_older=0`, `we=0`, `waddr=0`, `wdata=0`, `pending=0`, `busy=0`, `a_ready=b_ready=0` while `rst=1`.
  - Reset mid-operation discards held entries without writing them.

## Timing
- Latency: a request accepted at edge N is presented on `we/waddr/wdata` during cycle N+1 (after edge N+1) at the earliest. The register file commits it at edge N+2.
- Throughput: one write per cycle in total.
  - A lone source sustains one request per cycle, because ready stays 1 while its slot is granted.
  - Under contention, each slot waits at most one grant cycle.
- `we` is high for exactly one cycle per granted non-x0 entry; back-to-back grants give consecutive high cycles.
- Both slots full with the same address: the older slot is written first and the younger one on the next cycle, so the final value comes from the younger (A) entry.
- `pending` and `busy` reflect slot state after each edge and are glitch-free with respect to inputs.

## Test plan
- Reset then single A request (addr 5, data 0x11): `a_ready=1`, `pending[5]=1` after the accept edge, then `we=1, waddr=5, wdata=0x11` one cycle later; `pending=0` after that.
- A and B valid on the same edge (A: r3=0xAA, B: r3=0xBB): B is written first (`wdata=0xBB`), then A (`wdata=0xAA`) next cycle; both readies stay 1 and the final r3 is 0xAA.
- Continuous A stream with B arriving mid-stream: grants alternate by age, no request is lost or duplicated, and `we` stays high every cycle.
- A request to x0 (data 0xFF): the handshake completes and `pending[0]` stays 0; the output cycle shows `we=0`.
- `rdy` dropped for 3 cycles with both slots full: readies are 0, `we=0`, slots and `pending` are unchanged; after `rdy` returns, the writes resume in age order.
- `rst` asserted while both slots are full: the next cycle shows `we=0`, `pending=0`, `busy=0`; no write of the held data ever appears.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter that shares the single register-file write port between the
// ALU result path (slot A) and the load-data path (slot B), granting the oldest entry.
module regfile_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic [NREG-1:0]   pending,
    output logic              busy
);

    // One-hot decode of a destination register; x0 never reports as pending.
    function automatic logic [NREG-1:0] addr_onehot(input logic [ADDR_W-1:0] addr);
        logic [NREG-1:0] v;
        v = '0;
        for (int r = 1; r < NREG; r++) begin
            v[r] = (int'(addr) == r);
        end
        return v;
    endfunction

    logic              a_v_q, a_v_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic [DATA_W-1:0] a_data_q, a_data_d;
    logic              b_v_q, b_v_d;
    logic [ADDR_W-1:0] b_addr_q, b_addr_d;
    logic [DATA_W-1:0] b_data_q, b_data_d;
    logic              b_older_q, b_older_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              grant_a_s, grant_b_s;
    logic              acc_a_s, acc_b_s;

    // Grant from slot state only; rdy=0 freezes arbitration entirely.
    always_comb begin
        grant_a_s = rdy && a_v_q && (!b_v_q || !b_older_q);
        grant_b_s = rdy && b_v_q && (!a_v_q ||  b_older_q);
        a_ready   = !rst && rdy && (!a_v_q || grant_a_s);
        b_ready   = !rst && rdy && (!b_v_q || grant_b_s);
        acc_a_s   = a_valid && a_ready;
        acc_b_s   = b_valid && b_ready;
    end

    // Next-state for slots, age flag and the registered write port.
    always_comb begin
        a_v_d     = a_v_q;
        a_addr_d  = a_addr_q;
        a_data_d  = a_data_q;
        b_v_d     = b_v_q;
        b_addr_d  = b_addr_q;
        b_data_d  = b_data_q;
        b_older_d = b_older_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;

        if (grant_a_s) begin
            a_v_d = 1'b0;
        end else begin
            a_v_d = a_v_q;
        end
        if (acc_a_s) begin
            a_v_d    = 1'b1;
            a_addr_d = a_addr;
            a_data_d = a_data;
        end else begin
            a_addr_d = a_addr_q;
        end

        if (grant_b_s) begin
            b_v_d = 1'b0;
        end else begin
            b_v_d = b_v_q;
        end
        if (acc_b_s) begin
            b_v_d    = 1'b1;
            b_addr_d = b_addr;
            b_data_d = b_data;
        end else begin
            b_addr_d = b_addr_q;
        end

        // A MEM-stage load precedes the EX-stage result, so B wins simultaneous loads.
        if (acc_a_s) begin
            b_older_d = 1'b1;
        end else if (acc_b_s) begin
            b_older_d = !(a_v_q && !grant_a_s);
        end else begin
            b_older_d = b_older_q;
        end

        if (grant_a_s) begin
            we_d    = |a_addr_q;
            waddr_d = a_addr_q;
            wdata_d = a_data_q;
        end else if (grant_b_s) begin
            we_d    = |b_addr_q;
            waddr_d = b_addr_q;
            wdata_d = b_data_q;
        end else begin
            we_d    = 1'b0;
        end
    end

    // State registers with synchronous reset; reset drops held entries unwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_v_q     <= 1'b0;
            a_addr_q  <= '0;
            a_data_q  <= '0;
            b_v_q     <= 1'b0;
            b_addr_q  <= '0;
            b_data_q  <= '0;
            b_older_q <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            a_v_q     <= a_v_d;
            a_addr_q  <= a_addr_d;
            a_data_q  <= a_data_d;
            b_v_q     <= b_v_d;
            b_addr_q  <= b_addr_d;
            b_data_q  <= b_data_d;
            b_older_q <= b_older_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    // Status derived purely from registered slot state.
    always_comb begin
        pending = '0;
        if (a_v_q) begin
            pending = pending | addr_onehot(a_addr_q);
        end else begin
            pending = pending;
        end
        if (b_v_q) begin
            pending = pending | addr_onehot(b_addr_q);
        end else begin
            pending = pending;
        end
        busy  = a_v_q || b_v_q;
        we    = we_q;
        waddr = waddr_q;
        wdata = wdata_q;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes are queued in program
// order and a negedge monitor pops one per observed write strobe.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [4:0]  a_addr, b_addr, waddr;
    logic [31:0] a_data, b_data, wdata;
    logic        we, busy;
    logic [31:0] pending;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  vectors = 0;
    int  errors  = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .NREG(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .we(we), .waddr(waddr), .wdata(wdata), .pending(pending), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [4:0] addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        exp_q.push_back(w);
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {27'd0, waddr, wdata}, 64'd0);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("sb_waddr", {59'd0, waddr}, {59'd0, w.addr});
                check("sb_wdata", {32'd0, wdata}, {32'd0, w.data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  ia, cyc;
        bit  bsent, ra, rb;

        rst = 1'b1; rdy = 1'b0;
        a_valid = 1'b0; a_addr = 5'd0; a_data = 32'd0;
        b_valid = 1'b0; b_addr = 5'd0; b_data = 32'd0;
        tick(); tick();
        check("rst_we", {63'd0, we}, 64'd0);
        check("rst_waddr", {59'd0, waddr}, 64'd0);
        check("rst_wdata", {32'd0, wdata}, 64'd0);
        check("rst_pending", {32'd0, pending}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_ready", {62'd0, a_ready, b_ready}, 64'd0);
        rst = 1'b0; rdy = 1'b1;
        tick();

        // Single A request to r5.
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h11;
        #1 check("t1_a_ready", {63'd0, a_ready}, 64'd1);
        push(5'd5, 32'h11);
        tick();
        a_valid = 1'b0;
        check("t1_pending", {32'd0, pending}, 64'h20);
        check("t1_busy", {63'd0, busy}, 64'd1);
        tick();
        check("t1_we", {63'd0, we}, 64'd1);
        check("t1_pending_clr", {32'd0, pending}, 64'd0);
        tick();
        check("t1_we_drop", {63'd0, we}, 64'd0);

        // Simultaneous A and B to r3: B older, so A's value lands last.
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hAA;
        b_valid = 1'b1; b_addr = 5'd3; b_data = 32'hBB;
        #1 check("t2_readies", {62'd0, a_ready, b_ready}, 64'd3);
        push(5'd3, 32'hBB);
        push(5'd3, 32'hAA);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        check("t2_pending", {32'd0, pending}, 64'h8);
        tick();
        check("t2_first_data", {32'd0, wdata}, 64'hBB);
        check("t2_pending_a", {32'd0, pending}, 64'h8);
        tick();
        check("t2_final_data", {32'd0, wdata}, 64'hAA);
        check("t2_pending_clr", {32'd0, pending}, 64'd0);
        tick();

        // A stream r1..r6 with B (r20) joining alongside the third item.
        push(5'd1, 32'h100); push(5'd2, 32'h101); push(5'd20, 32'hB0);
        push(5'd3, 32'h102); push(5'd4, 32'h103); push(5'd5, 32'h104); push(5'd6, 32'h105);
        ia = 0; cyc = 0; bsent = 1'b0;
        while (ia < 6 && cyc < 50) begin
            a_valid = 1'b1; a_addr = 5'(ia + 1); a_data = 32'h100 + 32'(ia);
            if (ia == 2 && !bsent) begin
                b_valid = 1'b1; b_addr = 5'd20; b_data = 32'hB0;
            end else begin
                b_valid = 1'b0;
            end
            #1 ra = a_ready; rb = b_valid && b_ready;
            tick();
            cyc++;
            if (ra) ia++;
            if (rb) bsent = 1'b1;
            if (cyc >= 2) check("t3_we_high", {63'd0, we}, 64'd1);
        end
        check("t3_cycles", 64'(cyc), 64'd7);
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        check("t3_we_last", {63'd0, we}, 64'd1);
        tick();
        check("t3_we_idle", {63'd0, we}, 64'd0);

        // Write to x0 is consumed but never strobed.
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFF;
        #1 check("t4_a_ready", {63'd0, a_ready}, 64'd1);
        tick();
        a_valid = 1'b0;
        check("t4_pending", {32'd0, pending}, 64'd0);
        check("t4_busy", {63'd0, busy}, 64'd1);
        tick();
        check("t4_we", {63'd0, we}, 64'd0);
        check("t4_busy_clr", {63'd0, busy}, 64'd0);
        tick();

        // rdy low for three cycles with both slots full.
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77;
        b_valid = 1'b1; b_addr = 5'd8; b_data = 32'h88;
        tick();
        a_valid = 1'b0; b_valid = 1'b0; rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5_readies", {62'd0, a_ready, b_ready}, 64'd0);
            tick();
            check("t5_we", {63'd0, we}, 64'd0);
            check("t5_pending", {32'd0, pending}, 64'h180);
        end
        push(5'd8, 32'h88);
        push(5'd7, 32'h77);
        rdy = 1'b1;
        tick();
        check("t5_first", {59'd0, waddr}, 64'd8);
        tick();
        check("t5_second", {59'd0, waddr}, 64'd7);
        check("t5_pending_clr", {32'd0, pending}, 64'd0);
        tick();
        check("t5_hold_waddr", {59'd0, waddr}, 64'd7);
        check("t5_hold_wdata", {32'd0, wdata}, 64'h77);

        // Reset with both slots full: held data must never be written.
        a_valid = 1'b1; a_addr = 5'd9;  a_data = 32'h99;
        b_valid = 1'b1; b_addr = 5'd10; b_data = 32'hAB;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        check("t6_busy_full", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        tick();
        check("t6_we", {63'd0, we}, 64'd0);
        check("t6_pending", {32'd0, pending}, 64'd0);
        check("t6_busy", {63'd0, busy}, 64'd0);
        check("t6_waddr", {59'd0, waddr}, 64'd0);
        rst = 1'b0;
        tick(); tick(); tick();
        check("t6_busy_after", {63'd0, busy}, 64'd0);

        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
